// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, default MDU latencies and counter widths for stall_ctrl
package pipe_ctrl_pkg;
    typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_e;
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;
    localparam int CNT_W = 6;
    localparam int STALL_CNT_W = 32;
    localparam int FLUSH_CNT_W = 16;
endpackage

// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: hazard/MDU requests in, pipeline enables out; STALL_CTRL_PERF_EN adds perf counter outputs
interface stall_ctrl_if;
    logic hazard_i;
    logic branch_i;
    logic mdu_start_i;
    logic mdu_div_i;
    logic PCWrite_o;
    logic IF_IDWrite_o;
    logic Bubble_o;
    logic Flush_o;
    logic EX_Hold_o;
    logic mdu_busy_o;
    logic mdu_done_o;
`ifdef STALL_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
    modport master (output hazard_i, branch_i, mdu_start_i, mdu_div_i,
                    input PCWrite_o, IF_IDWrite_o, Bubble_o, Flush_o, EX_Hold_o, mdu_busy_o, mdu_done_o,
                    input stall_cnt_o, flush_cnt_o);
    modport slave (input hazard_i, branch_i, mdu_start_i, mdu_div_i,
                   output PCWrite_o, IF_IDWrite_o, Bubble_o, Flush_o, EX_Hold_o, mdu_busy_o, mdu_done_o,
                   output stall_cnt_o, flush_cnt_o);
`else
    modport master (output hazard_i, branch_i, mdu_start_i, mdu_div_i,
                    input PCWrite_o, IF_IDWrite_o, Bubble_o, Flush_o, EX_Hold_o, mdu_busy_o, mdu_done_o);
    modport slave (input hazard_i, branch_i, mdu_start_i, mdu_div_i,
                   output PCWrite_o, IF_IDWrite_o, Bubble_o, Flush_o, EX_Hold_o, mdu_busy_o, mdu_done_o);
`endif
endinterface

// File: rtl/mdu_lat_counter.sv
// mdu_lat_counter: loadable down-counter flagging the final MDU wait cycle when it reaches zero
module mdu_lat_counter import pipe_ctrl_pkg::*; (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // load takes precedence over decrement; zero marks the last wait cycle
    always_comb begin
        cnt_d = load_i ? load_val_i : dec_i ? cnt_q - 1'b1 : cnt_q;
        last_o = (cnt_q == '0);
    end
    // counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush/MDU-hold control; STALL_CTRL_PERF_EN adds stall and flush counters
module stall_ctrl import pipe_ctrl_pkg::*; #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input logic        clk_i,
    input logic        rst_i,
    stall_ctrl_if.slave bus
);
    // the start cycle and the final cycle are both stall cycles, so the counter holds LAT-2 wait cycles
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 2);
    state_e state_q, state_d;
    logic run, ld, mdu_act, last, pc_we, bubble, flush, done;
    mdu_lat_counter u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ld),
        .load_val_i (bus.mdu_div_i ? DIV_LD : MUL_LD),
        .dec_i      (~run & ~last),
        .last_o     (last)
    );
    // MDU outranks hazard, hazard outranks branch; requests are ignored while waiting on the MDU
    always_comb begin
        run = (state_q == RUN);
        ld = run & bus.mdu_start_i;
        mdu_act = ~run | bus.mdu_start_i;
        pc_we = ~(mdu_act | bus.hazard_i);
        bubble = ~mdu_act & bus.hazard_i;
        flush = ~mdu_act & ~bus.hazard_i & bus.branch_i;
        done = ~run & last;
        state_d = ld ? MDU_WAIT : done ? RUN : state_q;
        bus.PCWrite_o = pc_we;
        bus.IF_IDWrite_o = pc_we;
        bus.Bubble_o = bubble;
        bus.Flush_o = flush;
        bus.EX_Hold_o = mdu_act;
        bus.mdu_busy_o = mdu_act;
        bus.mdu_done_o = done;
    end
    // state register; reset aborts any MDU operation in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RUN;
        else state_q <= state_d;
    end
`ifdef STALL_CTRL_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    // free-running wrap-around event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(~pc_we);
        flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(flush);
        bus.stall_cnt_o = stall_cnt_q;
        bus.flush_cnt_o = flush_cnt_q;
    end
    // counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed and random checks of stall_ctrl against a cycle-budget reference model
module tb_stall_ctrl;
    localparam int MUL = 4;
    localparam int DIV = 32;
    logic clk = 0;
    logic rst = 1;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int rem = 0;
    int m_stall = 0;
    int m_flush = 0;
    stall_ctrl_if bus ();
    stall_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
        end
    endtask

    // reference model: rem = stall cycles still owed to the MDU including the current one
    always @(negedge clk) begin
        int eff;
        logic ms, e_pc, e_bub, e_fl, e_done;
        eff = (rem > 0) ? rem : (bus.mdu_start_i ? (bus.mdu_div_i ? DIV : MUL) : 0);
        ms = (eff > 0);
        e_pc = !(ms || bus.hazard_i);
        e_bub = !ms && bus.hazard_i;
        e_fl = !ms && !bus.hazard_i && bus.branch_i;
        e_done = (eff == 1);
        chk("pcwrite", bus.PCWrite_o, e_pc);
        chk("ifidwrite", bus.IF_IDWrite_o, e_pc);
        chk("bubble", bus.Bubble_o, e_bub);
        chk("flush", bus.Flush_o, e_fl);
        chk("ex_hold", bus.EX_Hold_o, ms);
        chk("busy", bus.mdu_busy_o, ms);
        chk("done", bus.mdu_done_o, e_done);
`ifdef STALL_CTRL_PERF_EN
        chk("stall_cnt", bus.stall_cnt_o, m_stall);
        chk("flush_cnt", {16'd0, bus.flush_cnt_o}, m_flush & 32'hffff);
        m_stall = rst ? 0 : m_stall + (e_pc ? 0 : 1);
        m_flush = rst ? 0 : m_flush + (e_fl ? 1 : 0);
`endif
        if (bus.mdu_done_o === 1'b1) done_cnt++;
        rem = rst ? 0 : (ms ? eff - 1 : 0);
    end

    task automatic tick(input logic s, input logic d, input logic h, input logic b, input logic r);
        @(posedge clk);
        #1;
        bus.mdu_start_i = s;
        bus.mdu_div_i = d;
        bus.hazard_i = h;
        bus.branch_i = b;
        rst = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int hold_n, done_at, bf_n, d0;
        bus.mdu_start_i = 0;
        bus.mdu_div_i = 0;
        bus.hazard_i = 0;
        bus.branch_i = 0;
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0);
            chk("idle_pc", bus.PCWrite_o, 1);
            chk("idle_ifid", bus.IF_IDWrite_o, 1);
            chk("idle_rest", {bus.Bubble_o, bus.Flush_o, bus.EX_Hold_o, bus.mdu_busy_o, bus.mdu_done_o}, 0);
        end
        hold_n = 0;
        done_at = -1;
        for (int i = 0; i < 8; i++) begin
            tick(i == 0, 0, 0, 0, 0);
            if (bus.EX_Hold_o === 1'b1) hold_n++;
            if (bus.mdu_done_o === 1'b1) done_at = (done_at < 0) ? i : 99;
            if (i == 4) chk("mul_pc_after", bus.PCWrite_o, 1);
        end
        chk("mul_hold_cycles", hold_n, 4);
        chk("mul_done_at", done_at, 3);
        hold_n = 0;
        done_at = -1;
        bf_n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(i == 0, i == 0, i >= 2 && i <= 10, i >= 2 && i <= 10, 0);
            if (bus.EX_Hold_o === 1'b1) hold_n++;
            if (bus.mdu_done_o === 1'b1) done_at = (done_at < 0) ? i : 99;
            if (i < 32 && (bus.Bubble_o !== 1'b0 || bus.Flush_o !== 1'b0)) bf_n++;
            if (i == 32) chk("div_pc_after", bus.PCWrite_o, 1);
        end
        chk("div_hold_cycles", hold_n, 32);
        chk("div_done_at", done_at, 31);
        chk("div_no_bubble_flush", bf_n, 0);
        tick(0, 0, 1, 1, 0);
        chk("hb_bubble", bus.Bubble_o, 1);
        chk("hb_flush", bus.Flush_o, 0);
        tick(0, 0, 0, 1, 0);
        chk("b_flush", bus.Flush_o, 1);
        chk("b_bubble", bus.Bubble_o, 0);
        chk("b_pc", bus.PCWrite_o, 1);
        tick(0, 0, 0, 0, 0);
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) tick(i == 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        chk("abort_pc", bus.PCWrite_o, 1);
        chk("abort_hold", bus.EX_Hold_o, 0);
        chk("abort_busy", bus.mdu_busy_o, 0);
        for (int i = 0; i < 40; i++) tick(0, 0, 0, 0, 0);
        chk("abort_no_done", done_cnt - d0, 0);
`ifdef STALL_CTRL_PERF_EN
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        chk("perf_stall", bus.stall_cnt_o, 6);
        chk("perf_flush", {16'd0, bus.flush_cnt_o}, 1);
`endif
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(15) == 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
                 $urandom_range(3) == 0, $urandom_range(199) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4: stall cycles for an issued multiply; legal range 2..64.
REQ-002 Parameter DIV_LAT, default 32: stall cycles for an issued divide; legal range 2..64.
REQ-003 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 hazard_i  input  1  load-use hazard request from the hazard detection unit.
REQ-006 branch_i  input  1  taken branch resolved in ID; IF must be flushed.
REQ-007 mdu_start_i  input  1  multiply/divide instruction in EX requests the MDU.
REQ-008 mdu_div_i  input  1  qualifies mdu_start_i: 1 = divide, 0 = multiply.
REQ-009 PCWrite_o  output  1  PC update enable.
REQ-010 IF_IDWrite_o  output  1  IF/ID register write enable.
REQ-011 Bubble_o  output  1  select NOP control into ID/EX.
REQ-012 Flush_o  output  1  clear IF/ID (squash fetched instruction).
REQ-013 EX_Hold_o  output  1  hold ID/EX and EX/MEM registers (MDU busy).
REQ-014 mdu_busy_o  output  1  MDU operation in progress.
REQ-015 mdu_done_o  output  1  one-cycle pulse: MDU result valid.

Function
REQ-016 The FSM SHALL have two states: RUN and MDU_WAIT, plus an MDU latency counter of 6 bits.
REQ-017 In RUN with no requests, outputs SHALL be PCWrite_o=1, IF_IDWrite_o=1, all others 0.
REQ-018 Priority SHALL be: MDU (start or wait) > hazard_i > branch_i.
REQ-019 RUN, mdu_start_i=1 in cycle N: PCWrite_o=0, IF_IDWrite_o=0, EX_Hold_o=1, mdu_busy_o=1 combinationally in N; next state MDU_WAIT.
REQ-020 Stall SHALL last exactly LAT cycles (N..N+LAT-1), LAT = DIV_LAT if mdu_div_i=1 in N else MUL_LAT; mdu_div_i is sampled only in N.
REQ-021 mdu_done_o SHALL pulse in cycle N+LAT-1 only; state returns to RUN for cycle N+LAT.
REQ-022 In MDU_WAIT, hazard_i, branch_i and mdu_start_i SHALL be ignored; Bubble_o=0, Flush_o=0.
REQ-023 RUN, hazard_i=1 (no MDU): PCWrite_o=0, IF_IDWrite_o=0, Bubble_o=1 for that cycle; no state change.
REQ-024 RUN, branch_i=1 (no hazard, no MDU): Flush_o=1, PCWrite_o=1, IF_IDWrite_o=1.
REQ-025 hazard_i and branch_i together: hazard wins, Flush_o=0; branch remains held in ID and flushes the following cycle.
REQ-026 Outputs SHALL be combinational from current state and inputs; no output latency beyond REQ-019..021.

Reset
REQ-027 rst_i=1 at an edge SHALL force state RUN, counter 0, and any performance counters to 0.
REQ-028 Reset mid-MDU_WAIT SHALL abort the operation with no mdu_done_o pulse.
REQ-029 Post-reset outputs SHALL equal REQ-017 values.

Configuration
REQ-030 Macro STALL_CTRL_PERF_EN defined: add outputs stall_cnt_o (32-bit, increments each cycle PCWrite_o=0) and flush_cnt_o (16-bit, increments each cycle Flush_o=1); both wrap to 0 on overflow.
REQ-031 Macro undefined: those ports and counters SHALL NOT exist; all other behaviour identical.

Structure
REQ-032 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, MDU_WAIT), default MUL_LAT/DIV_LAT constants and counter width.
REQ-033 Sub-module mdu_lat_counter (load value, decrement, last-cycle flag) SHALL implement the latency counter.

Verification
REQ-034 Reset then idle 3 cycles -> PCWrite_o=1, IF_IDWrite_o=1, all others 0 each cycle.
REQ-035 mdu_start_i=1, mdu_div_i=0 at cycle 10 -> EX_Hold_o=1 cycles 10..13, mdu_done_o=1 cycle 13 only, PCWrite_o=1 cycle 14.
REQ-036 mdu_start_i=1, mdu_div_i=1 at cycle 10, hazard_i=1 and branch_i=1 cycles 12..20 -> stall cycles 10..41, Bubble_o=0, Flush_o=0 throughout, done pulse cycle 41.
REQ-037 hazard_i=1 and branch_i=1 cycle 5, branch_i=1 cycle 6 -> cycle 5 Bubble_o=1, Flush_o=0; cycle 6 Flush_o=1, Bubble_o=0.
REQ-038 Divide started cycle 10, rst_i=1 cycle 20 -> cycle 21 RUN outputs, no mdu_done_o ever pulses.
REQ-039 With STALL_CTRL_PERF_EN: one multiply plus two hazard cycles plus one branch -> stall_cnt_o=6, flush_cnt_o=1.
